// File: rtl/game_pkg.sv
// game_pkg: shared screen/sprite geometry and overlap helper for game controllers
package game_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PLAYER_SIZE = 32;
  localparam int ENEMY_SIZE = 32;
  localparam int BULLET_SIZE = 8;
  localparam int SPAWN_X_OFF = (ENEMY_SIZE - BULLET_SIZE) / 2;
  localparam int SPAWN_Y_OFF = ENEMY_SIZE;
  localparam int BOTTOM_LIMIT = SCREEN_H - BULLET_SIZE;
  function automatic logic overlap(input logic [10:0] a, input logic [10:0] asz, input logic [10:0] b, input logic [10:0] bsz);
    return (a + asz > b) && (a < b + bsz);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[W'((int'(ptr) + i) % N)]) begin
        idx = W'((int'(ptr) + i) % N);
        valid = 1'b1;
      end
    end
    grant = valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/enemy_bullet_controller.sv
// enemy_bullet_controller: enemy bullet spawning, downward motion and player collision
module enemy_bullet_controller
  import game_pkg::*;
#(
  parameter int EBULLET_COUNT = 8,
  parameter int SHOOTER_COUNT = 4,
  parameter int FIRE_DIV = 12_500_000,
  parameter int MOVE_DIV = 250_000,
  parameter int STEP = 2
) (
  input  logic                       clk25,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [10*SHOOTER_COUNT-1:0] shooter_x_flat,
  input  logic [10*SHOOTER_COUNT-1:0] shooter_y_flat,
  input  logic [SHOOTER_COUNT-1:0]   shooter_alive,
  input  logic [9:0]                 player_x,
  input  logic [9:0]                 player_y,
  output logic [10*EBULLET_COUNT-1:0] ebullet_x_flat,
  output logic [10*EBULLET_COUNT-1:0] ebullet_y_flat,
  output logic [EBULLET_COUNT-1:0]   ebullet_active_flat,
  output logic                       player_hit,
  output logic [7:0]                 hit_count
);
  localparam int FW = (FIRE_DIV > 1) ? $clog2(FIRE_DIV) : 1;
  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int SW = (SHOOTER_COUNT > 1) ? $clog2(SHOOTER_COUNT) : 1;
  localparam int EW = (EBULLET_COUNT > 1) ? $clog2(EBULLET_COUNT) : 1;
  logic [FW-1:0] fire_cnt;
  logic [MW-1:0] move_cnt;
  logic [SW-1:0] ptr, arb_idx;
  logic [SHOOTER_COUNT-1:0] arb_grant;
  logic arb_valid, fire, move, spawn, free_valid;
  logic [EW-1:0] free_idx;
  logic [9:0] sx [SHOOTER_COUNT];
  logic [9:0] sy [SHOOTER_COUNT];
  logic [9:0] bx [EBULLET_COUNT];
  logic [9:0] by [EBULLET_COUNT];
  logic [EBULLET_COUNT-1:0] active, hit;
  logic [9:0] sel_x, sel_y, spawn_x;
  logic [10:0] spawn_y;
  assign fire = enable && fire_cnt == FW'(FIRE_DIV - 1);
  assign move = move_cnt == MW'(MOVE_DIV - 1);
  assign spawn_x = sel_x + 10'(SPAWN_X_OFF);
  assign spawn_y = {1'b0, sel_y} + 11'(SPAWN_Y_OFF);
  assign spawn = fire && arb_valid && free_valid && spawn_y <= 11'(BOTTOM_LIMIT);
  assign ebullet_active_flat = active;
  rr_arbiter #(.N(SHOOTER_COUNT)) u_arb (
    .req(shooter_alive),
    .ptr(ptr),
    .grant(arb_grant),
    .idx(arb_idx),
    .valid(arb_valid)
  );
  for (genvar s = 0; s < SHOOTER_COUNT; s++) begin : g_shooter
    assign sx[s] = shooter_x_flat[s*10 +: 10];
    assign sy[s] = shooter_y_flat[s*10 +: 10];
  end
  for (genvar i = 0; i < EBULLET_COUNT; i++) begin : g_slot
    assign hit[i] = active[i]
      && overlap({1'b0, bx[i]}, 11'(BULLET_SIZE), {1'b0, player_x}, 11'(PLAYER_SIZE))
      && overlap({1'b0, by[i]}, 11'(BULLET_SIZE), {1'b0, player_y}, 11'(PLAYER_SIZE));
    assign ebullet_x_flat[i*10 +: 10] = bx[i];
    assign ebullet_y_flat[i*10 +: 10] = by[i];
  end
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int j = 0; j < SHOOTER_COUNT; j++) begin
      sel_x = arb_grant[j] ? sx[j] : sel_x;
      sel_y = arb_grant[j] ? sy[j] : sel_y;
    end
  end
  always_comb begin
    free_valid = 1'b0;
    free_idx = '0;
    for (int j = EBULLET_COUNT - 1; j >= 0; j--) begin
      if (!active[j]) begin
        free_valid = 1'b1;
        free_idx = EW'(j);
      end
    end
  end
  always_ff @(posedge clk25) begin
    if (reset) begin
      fire_cnt <= '0;
      move_cnt <= '0;
      ptr <= '0;
      player_hit <= 1'b0;
      hit_count <= '0;
      active <= '0;
      for (int j = 0; j < EBULLET_COUNT; j++) begin
        bx[j] <= '0;
        by[j] <= '0;
      end
    end else begin
      fire_cnt <= (!enable || fire) ? '0 : fire_cnt + 1'b1;
      move_cnt <= move ? '0 : move_cnt + 1'b1;
      if (spawn) ptr <= (arb_idx == SW'(SHOOTER_COUNT - 1)) ? '0 : arb_idx + 1'b1;
      player_hit <= |hit;
      if (|hit && hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
      for (int j = 0; j < EBULLET_COUNT; j++) begin
        if (hit[j]) begin
          active[j] <= 1'b0;
        end else if (move && active[j]) begin
          if ({1'b0, by[j]} + 11'(STEP) > 11'(BOTTOM_LIMIT)) active[j] <= 1'b0;
          else by[j] <= by[j] + 10'(STEP);
        end else if (spawn && free_idx == EW'(j)) begin
          active[j] <= 1'b1;
          bx[j] <= spawn_x;
          by[j] <= spawn_y[9:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_enemy_bullet_controller.sv
// tb_enemy_bullet_controller: directed checks of spawning, motion, hits and reset
module tb_enemy_bullet_controller;
  logic clk25 = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [39:0] sx_flat = '0;
  logic [39:0] sy_flat = '0;
  logic [3:0] alive = '0;
  logic [9:0] px = '0;
  logic [9:0] py = '0;
  logic [79:0] ex_flat, ey_flat;
  logic [7:0] eactive;
  logic phit;
  logic [7:0] hcount;
  int checks = 0;
  int errors = 0;
  always #5 clk25 = ~clk25;
  enemy_bullet_controller #(
    .EBULLET_COUNT(8), .SHOOTER_COUNT(4), .FIRE_DIV(16), .MOVE_DIV(4), .STEP(2)
  ) dut (
    .clk25(clk25),
    .reset(reset),
    .enable(enable),
    .shooter_x_flat(sx_flat),
    .shooter_y_flat(sy_flat),
    .shooter_alive(alive),
    .player_x(px),
    .player_y(py),
    .ebullet_x_flat(ex_flat),
    .ebullet_y_flat(ey_flat),
    .ebullet_active_flat(eactive),
    .player_hit(phit),
    .hit_count(hcount)
  );
  function automatic logic [9:0] bx_of(input int k);
    return ex_flat[k*10 +: 10];
  endfunction
  function automatic logic [9:0] by_of(input int k);
    return ey_flat[k*10 +: 10];
  endfunction
  task automatic tick(input int n);
    repeat (n) @(negedge clk25);
  endtask
  task automatic do_reset;
    @(negedge clk25);
    reset = 1'b1;
    enable = 1'b0;
    alive = '0;
    sx_flat = '0;
    sy_flat = '0;
    px = '0;
    py = '0;
    @(negedge clk25);
    reset = 1'b0;
  endtask
  task automatic set_shooter(input int j, input logic [9:0] x, input logic [9:0] y);
    sx_flat[j*10 +: 10] = x;
    sy_flat[j*10 +: 10] = y;
  endtask
  task automatic test_reset;
    do_reset();
    checks++;
    if (eactive !== 8'h00) begin errors++; $display("FAIL reset_active got %h exp 00", eactive); end
    checks++;
    if (phit !== 1'b0 || hcount !== 8'd0) begin errors++; $display("FAIL reset_hit got %b/%0d exp 0/0", phit, hcount); end
    checks++;
    if (ex_flat !== '0 || ey_flat !== '0) begin errors++; $display("FAIL reset_pos got %h/%h exp 0", ex_flat, ey_flat); end
  endtask
  task automatic test_spawn;
    do_reset();
    enable = 1'b1;
    alive = 4'b0001;
    set_shooter(0, 10'd100, 10'd50);
    tick(15);
    checks++;
    if (eactive !== 8'h00) begin errors++; $display("FAIL spawn_early got %h exp 00", eactive); end
    tick(1);
    checks++;
    if (eactive !== 8'h01) begin errors++; $display("FAIL spawn_active got %h exp 01", eactive); end
    checks++;
    if (bx_of(0) !== 10'd112 || by_of(0) !== 10'd82) begin errors++; $display("FAIL spawn_pos got (%0d,%0d) exp (112,82)", bx_of(0), by_of(0)); end
    tick(4);
    checks++;
    if (by_of(0) !== 10'd84) begin errors++; $display("FAIL move_step got %0d exp 84", by_of(0)); end
  endtask
  task automatic test_round_robin;
    int exp_all[5] = '{112, 212, 312, 412, 112};
    int exp_dead[4] = '{112, 212, 412, 112};
    do_reset();
    enable = 1'b1;
    alive = 4'b1111;
    for (int j = 0; j < 4; j++) set_shooter(j, 10'(100 + 100 * j), 10'd50);
    tick(80);
    checks++;
    if (eactive !== 8'h1F) begin errors++; $display("FAIL rr_active got %h exp 1f", eactive); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bx_of(k) !== 10'(exp_all[k])) begin errors++; $display("FAIL rr_x slot %0d got %0d exp %0d", k, bx_of(k), exp_all[k]); end
    end
    do_reset();
    enable = 1'b1;
    alive = 4'b1011;
    for (int j = 0; j < 4; j++) set_shooter(j, 10'(100 + 100 * j), 10'd50);
    tick(64);
    checks++;
    if (eactive !== 8'h0F) begin errors++; $display("FAIL rr_dead_active got %h exp 0f", eactive); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bx_of(k) !== 10'(exp_dead[k])) begin errors++; $display("FAIL rr_dead_x slot %0d got %0d exp %0d", k, bx_of(k), exp_dead[k]); end
    end
  endtask
  task automatic test_slots_full;
    do_reset();
    enable = 1'b1;
    alive = 4'b1111;
    for (int j = 0; j < 4; j++) set_shooter(j, 10'(100 + 100 * j), 10'd50);
    tick(144);
    checks++;
    if (eactive !== 8'hFF || bx_of(0) !== 10'd112) begin errors++; $display("FAIL full_nochange got %h x0=%0d exp ff x0=112", eactive, bx_of(0)); end
    tick(15);
    checks++;
    if (by_of(0) !== 10'd152) begin errors++; $display("FAIL full_y0 got %0d exp 152", by_of(0)); end
    px = 10'd108;
    py = 10'd140;
    tick(1);
    px = '0;
    py = '0;
    checks++;
    if (eactive !== 8'hFE || phit !== 1'b1 || hcount !== 8'd1) begin errors++; $display("FAIL full_free got %h/%b/%0d exp fe/1/1", eactive, phit, hcount); end
    tick(16);
    checks++;
    if (eactive !== 8'hFF || bx_of(0) !== 10'd112 || by_of(0) !== 10'd82) begin errors++; $display("FAIL full_respawn got %h (%0d,%0d) exp ff (112,82)", eactive, bx_of(0), by_of(0)); end
  endtask
  task automatic test_offscreen;
    do_reset();
    enable = 1'b1;
    alive = 4'b0001;
    set_shooter(0, 10'd100, 10'd438);
    tick(16);
    checks++;
    if (eactive !== 8'h01 || by_of(0) !== 10'd470) begin errors++; $display("FAIL off_spawn got %h y=%0d exp 01 y=470", eactive, by_of(0)); end
    tick(4);
    checks++;
    if (eactive !== 8'h01 || by_of(0) !== 10'd472) begin errors++; $display("FAIL off_472 got %h y=%0d exp 01 y=472", eactive, by_of(0)); end
    tick(4);
    checks++;
    if (eactive !== 8'h00 || by_of(0) !== 10'd472) begin errors++; $display("FAIL off_clear got %h y=%0d exp 00 y=472", eactive, by_of(0)); end
    do_reset();
    enable = 1'b1;
    alive = 4'b0001;
    set_shooter(0, 10'd100, 10'd441);
    tick(16);
    checks++;
    if (eactive !== 8'h00) begin errors++; $display("FAIL off_nospawn got %h exp 00", eactive); end
    set_shooter(0, 10'd100, 10'd440);
    tick(16);
    checks++;
    if (eactive !== 8'h01 || by_of(0) !== 10'd472) begin errors++; $display("FAIL off_edge_spawn got %h y=%0d exp 01 y=472", eactive, by_of(0)); end
    tick(4);
    checks++;
    if (eactive !== 8'h00 || by_of(0) !== 10'd472) begin errors++; $display("FAIL off_edge_clear got %h y=%0d exp 00 y=472", eactive, by_of(0)); end
  endtask
  task automatic test_hit;
    do_reset();
    enable = 1'b1;
    alive = 4'b0001;
    set_shooter(0, 10'd100, 10'd50);
    px = 10'd108;
    py = 10'd100;
    tick(16);
    enable = 1'b0;
    tick(24);
    checks++;
    if (eactive !== 8'h01 || by_of(0) !== 10'd94 || phit !== 1'b0) begin errors++; $display("FAIL hit_before got %h y=%0d p=%b exp 01 y=94 p=0", eactive, by_of(0), phit); end
    tick(1);
    checks++;
    if (eactive !== 8'h00 || phit !== 1'b1 || hcount !== 8'd1 || by_of(0) !== 10'd94) begin errors++; $display("FAIL hit_event got %h p=%b c=%0d y=%0d exp 00 1 1 94", eactive, phit, hcount, by_of(0)); end
    tick(1);
    checks++;
    if (phit !== 1'b0 || hcount !== 8'd1) begin errors++; $display("FAIL hit_pulse got %b/%0d exp 0/1", phit, hcount); end
    do_reset();
    enable = 1'b1;
    alive = 4'b0011;
    set_shooter(0, 10'd100, 10'd50);
    set_shooter(1, 10'd100, 10'd50);
    tick(32);
    enable = 1'b0;
    checks++;
    if (eactive !== 8'h03 || by_of(0) !== 10'd90 || by_of(1) !== 10'd82) begin errors++; $display("FAIL dual_setup got %h y0=%0d y1=%0d exp 03 90 82", eactive, by_of(0), by_of(1)); end
    px = 10'd108;
    py = 10'd80;
    tick(1);
    checks++;
    if (eactive !== 8'h00 || phit !== 1'b1 || hcount !== 8'd1) begin errors++; $display("FAIL dual_hit got %h/%b/%0d exp 00/1/1", eactive, phit, hcount); end
    tick(1);
    checks++;
    if (phit !== 1'b0 || hcount !== 8'd1) begin errors++; $display("FAIL dual_pulse got %b/%0d exp 0/1", phit, hcount); end
  endtask
  task automatic test_reset_midflight;
    do_reset();
    enable = 1'b1;
    alive = 4'b1111;
    for (int j = 0; j < 4; j++) set_shooter(j, 10'(100 + 100 * j), 10'd50);
    tick(80);
    checks++;
    if (eactive !== 8'h1F) begin errors++; $display("FAIL mid_before got %h exp 1f", eactive); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if (eactive !== 8'h00 || ex_flat !== '0 || ey_flat !== '0) begin errors++; $display("FAIL mid_reset got %h exp 00 with zero positions", eactive); end
  endtask
  task automatic test_saturation;
    do_reset();
    enable = 1'b1;
    alive = 4'b0001;
    set_shooter(0, 10'd100, 10'd50);
    px = 10'd108;
    py = 10'd80;
    tick(16 * 255 + 1);
    checks++;
    if (hcount !== 8'd255 || phit !== 1'b1) begin errors++; $display("FAIL sat_255 got %0d/%b exp 255/1", hcount, phit); end
    tick(16);
    checks++;
    if (hcount !== 8'd255 || phit !== 1'b1 || eactive !== 8'h00) begin errors++; $display("FAIL sat_hold got %0d/%b/%h exp 255/1/00", hcount, phit, eactive); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if (hcount !== 8'd0 || phit !== 1'b0) begin errors++; $display("FAIL sat_reset got %0d/%b exp 0/0", hcount, phit); end
  endtask
  initial begin
    test_reset();
    test_spawn();
    test_round_robin();
    test_slots_full();
    test_offscreen();
    test_hit();
    test_reset_midflight();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
